// File: rtl/vicii_sync_decoder.sv
// Separates VIC-II composite sync from luma, classifies pulses by width and emits an active-area pixel stream.
// Optional per-frame CRC-16-CCITT over active luma is enabled by defining VICII_SYNC_DECODER_CRC_EN.
module vicii_sync_decoder #(
  parameter int HSYNC_MIN = 16,
  parameter int VSYNC_MIN = 128,
  parameter int H_START   = 80,
  parameter int H_WIDTH   = 384,
  parameter int V_START   = 16,
  parameter int V_HEIGHT  = 272
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic [5:0]  sync_lumen,
  output logic        locked,
  output logic        hsync,
  output logic        frame_start,
  output logic        pixel_valid,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic [5:0]  luma,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  pw_q, pw_d;
  logic [9:0]  hcount_q, hcount_d;
  logic [8:0]  vcount_q, vcount_d;
  logic        vsync_pending_q, vsync_pending_d;
  logic        locked_q, locked_d;
  logic        hsync_q, hsync_d;
  logic        frame_start_q, frame_start_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [8:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [5:0]  luma_q, luma_d;

  logic        sync_in;
  logic        trailing_edge;
  logic        is_hsync;
  logic        is_broad;
  logic        in_h;
  logic        in_v;
  logic [9:0]  h_cur;
  logic [8:0]  v_cur;
  logic [31:0] pw_ext;
  logic [31:0] h_ext;
  logic [31:0] v_ext;

  // h_cur/v_cur are the position of the sample being registered this cycle, after any
  // trailing-edge restart; the held counters describe the sample that would follow.
  always_comb begin
    sync_in         = (sync_lumen == 6'd0);
    trailing_edge   = !sync_in && hsync_q;
    pw_ext          = {22'd0, pw_q};
    is_hsync        = trailing_edge && (pw_ext >= HSYNC_MIN) && (pw_ext < VSYNC_MIN);
    is_broad        = trailing_edge && (pw_ext >= VSYNC_MIN);

    state_d         = state_q;
    vsync_pending_d = vsync_pending_q;
    frame_start_d   = 1'b0;
    h_cur           = hcount_q;
    v_cur           = vcount_q;

    if (sync_in) begin
      pw_d = (pw_q == 10'h3FF) ? pw_q : pw_q + 10'd1;
    end else begin
      pw_d = 10'd0;
    end

    if (is_hsync) begin
      h_cur = 10'd0;
      if (vsync_pending_q) begin
        v_cur           = 9'd0;
        frame_start_d   = 1'b1;
        vsync_pending_d = 1'b0;
        state_d         = ST_LOCKED;
      end else begin
        v_cur = (vcount_q == 9'h1FF) ? vcount_q : vcount_q + 9'd1;
      end
    end else if (is_broad) begin
      h_cur           = 10'd0;
      vsync_pending_d = 1'b1;
    end else if (state_q == ST_LOCKED && (hcount_q == 10'h3FF || pw_q == 10'h3FF)) begin
      state_d         = ST_UNLOCKED;
      vsync_pending_d = 1'b0;
    end

    if (sync_in) begin
      hcount_d = hcount_q;
    end else begin
      hcount_d = (h_cur == 10'h3FF) ? h_cur : h_cur + 10'd1;
    end
    vcount_d = v_cur;

    h_ext = {22'd0, h_cur};
    v_ext = {23'd0, v_cur};
    in_h  = (h_ext >= H_START) && (h_ext < H_START + H_WIDTH);
    in_v  = (v_ext >= V_START) && (v_ext < V_START + V_HEIGHT);

    locked_d      = (state_d == ST_LOCKED);
    pixel_valid_d = locked_d && in_h && in_v && !sync_in;
    x_d           = pixel_valid_d ? 9'(h_ext - 32'(H_START)) : 9'd0;
    y_d           = pixel_valid_d ? 9'(v_ext - 32'(V_START)) : 9'd0;
    luma_d        = sync_lumen;
    hsync_d       = sync_in;
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_UNLOCKED;
      pw_q            <= 10'd0;
      hcount_q        <= 10'd0;
      vcount_q        <= 9'd0;
      vsync_pending_q <= 1'b0;
      locked_q        <= 1'b0;
      hsync_q         <= 1'b0;
      frame_start_q   <= 1'b0;
      pixel_valid_q   <= 1'b0;
      x_q             <= 9'd0;
      y_q             <= 9'd0;
      luma_q          <= 6'd0;
    end else begin
      state_q         <= state_d;
      pw_q            <= pw_d;
      hcount_q        <= hcount_d;
      vcount_q        <= vcount_d;
      vsync_pending_q <= vsync_pending_d;
      locked_q        <= locked_d;
      hsync_q         <= hsync_d;
      frame_start_q   <= frame_start_d;
      pixel_valid_q   <= pixel_valid_d;
      x_q             <= x_d;
      y_q             <= y_d;
      luma_q          <= luma_d;
    end
  end

  assign locked      = locked_q;
  assign hsync       = hsync_q;
  assign frame_start = frame_start_q;
  assign pixel_valid = pixel_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign luma        = luma_q;

`ifdef VICII_SYNC_DECODER_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        crc_valid_q, crc_valid_d;
  logic        crc_seen_q, crc_seen_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // The first frame_start after reset only seeds the running value; there is no prior frame to report.
  always_comb begin
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    crc_valid_d = 1'b0;
    crc_seen_d  = crc_seen_q;
    if (frame_start_d) begin
      if (crc_seen_q) begin
        frame_crc_d = crc_q;
        crc_valid_d = 1'b1;
      end
      crc_seen_d = 1'b1;
      crc_d      = 16'hFFFF;
    end else if (pixel_valid_d) begin
      crc_d = crc16_byte(crc_q, {2'b00, sync_lumen});
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= 16'hFFFF;
      crc_valid_q <= 1'b0;
      crc_seen_q  <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
      crc_valid_q <= crc_valid_d;
      crc_seen_q  <= crc_seen_d;
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`else
  assign frame_crc = 16'hFFFF;
  assign crc_valid = 1'b0;
`endif

endmodule
